ppt_pulse_gen_multi: RTL and testbench

Multi-channel, parametrised pulse-train generator for the PPT controller. It replaces the single-channel 8-bit pulse core behind the I2C register file. Each channel emits COUNT pulses of WIDTH clocks at a PERIOD-clock pitch, or runs continuously, and reports its progress and completion. The block sits between the I2C slave's byte-wide register bus and the `uo_out` pins.

---
 rtl/ppt_pkg.sv | 38 +++
 rtl/ppt_channel.sv | 152 +++++++++++++++
 rtl/ppt_pulse_gen_multi.sv | 109 ++++++++++
 tb/tb_ppt_pulse_gen_multi.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ppt_pkg.sv
// Shared definitions for the multi-channel pulse-train generator:
// register map offsets, CTRL/STATUS bit positions, channel state type
// and byte access helpers for the 16-bit register view.
package ppt_pkg;

   localparam logic [3:0] OFF_PERIOD_L = 4'h0;
   localparam logic [3:0] OFF_PERIOD_H = 4'h1;
   localparam logic [3:0] OFF_WIDTH_L  = 4'h2;
   localparam logic [3:0] OFF_WIDTH_H  = 4'h3;
   localparam logic [3:0] OFF_COUNT_L  = 4'h4;
   localparam logic [3:0] OFF_COUNT_H  = 4'h5;
   localparam logic [3:0] OFF_CTRL     = 4'h6;
   localparam logic [3:0] OFF_DONE_L   = 4'h8;
   localparam logic [3:0] OFF_DONE_H   = 4'h9;
   localparam logic [3:0] OFF_STATUS   = 4'hA;

   localparam int CTRL_RUN  = 0;
   localparam int CTRL_CONT = 1;
   localparam int CTRL_POL  = 2;

   localparam int STAT_DONE = 0;
   localparam int STAT_BUSY = 1;
   localparam int STAT_ERR  = 2;

   typedef enum logic [1:0] {IDLE, HIGH, LOW, DONE} ppt_state_t;

   // Replace the low (hi=0) or high (hi=1) byte of a 16-bit value.
   function automatic logic [15:0] set_byte(input logic [15:0] v, input logic hi,
                                            input logic [7:0] b);
      set_byte = hi ? {b, v[7:0]} : {v[15:8], b};
   endfunction

   // Pick the low (hi=0) or high (hi=1) byte of a 16-bit value.
   function automatic logic [7:0] get_byte(input logic [15:0] v, input logic hi);
      get_byte = hi ? v[15:8] : v[7:0];
   endfunction

endpackage

// File: rtl/ppt_channel.sv
// One pulse-train channel: config registers, run snapshot, IDLE/HIGH/LOW/DONE
// FSM, phase and completed-pulse counters, output polarity.
module ppt_channel
   import ppt_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             we,
   input  logic [3:0]       offset,
   input  logic [7:0]       wdata,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] width,
   output logic [CNT_W-1:0] count,
   output logic [CNT_W-1:0] done_cnt,
   output logic             run,
   output logic             cont,
   output logic             pol,
   output logic             done,
   output logic             err,
   output logic             pulse_out,
   output logic             done_irq,
   output ppt_state_t       state
);

   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] s_period, s_width, s_count, phase, width_clamped;
   logic             s_cont, s_pol, start_pend;
   logic             wr_ctrl, cont_nx, pol_nx, start_now, stop_now, busy;

   // Decode run start/stop requests and derive the pin level from registered state.
   always_comb begin
      wr_ctrl       = we && (offset == OFF_CTRL);
      cont_nx       = wr_ctrl ? wdata[CTRL_CONT] : cont;
      pol_nx        = wr_ctrl ? wdata[CTRL_POL] : pol;
      busy          = (state == HIGH) || (state == LOW);
      // A RUN 0->1 write that lands while ena is low is remembered until ena returns.
      start_now     = (wr_ctrl && wdata[CTRL_RUN] && !run) || start_pend;
      stop_now      = wr_ctrl && !wdata[CTRL_RUN] && busy;
      width_clamped = (width >= period) ? (period - ONE) : width;
      // While running the snapshot polarity applies; otherwise the idle level is CTRL.POL.
      pulse_out     = busy ? ((state == HIGH) ^ s_pol) : pol;
   end

   // Register writes plus the channel FSM; FSM assignments win over plain register writes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         period     <= '0;
         width      <= '0;
         count      <= '0;
         done_cnt   <= '0;
         run        <= 1'b0;
         cont       <= 1'b0;
         pol        <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         done_irq   <= 1'b0;
         state      <= IDLE;
         s_period   <= '0;
         s_width    <= '0;
         s_count    <= '0;
         s_cont     <= 1'b0;
         s_pol      <= 1'b0;
         phase      <= '0;
         start_pend <= 1'b0;
      end else begin
         done_irq <= 1'b0;
         if (we) begin
            case (offset)
               OFF_PERIOD_L, OFF_PERIOD_H: period <= CNT_W'(set_byte(16'(period), offset[0], wdata));
               OFF_WIDTH_L, OFF_WIDTH_H:   width  <= CNT_W'(set_byte(16'(width), offset[0], wdata));
               OFF_COUNT_L, OFF_COUNT_H:   count  <= CNT_W'(set_byte(16'(count), offset[0], wdata));
               OFF_CTRL: begin
                  run  <= wdata[CTRL_RUN];
                  cont <= wdata[CTRL_CONT];
                  pol  <= wdata[CTRL_POL];
               end
               default: ;
            endcase
         end

         if (wr_ctrl && !wdata[CTRL_RUN]) start_pend <= 1'b0;

         if (stop_now) begin
            // Abort: back to idle, DONE_CNT kept, DONE not set.
            state <= IDLE;
         end else if (ena) begin
            case (state)
               IDLE, DONE: begin
                  if (start_now) begin
                     start_pend <= 1'b0;
                     s_period   <= period;
                     s_width    <= width_clamped;
                     s_count    <= count;
                     s_cont     <= cont_nx;
                     s_pol      <= pol_nx;
                     done       <= 1'b0;
                     err        <= 1'b0;
                     done_cnt   <= '0;
                     phase      <= ONE;
                     if (period == '0 || width == '0) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        err      <= 1'b1;
                        run      <= 1'b0;
                        done_irq <= 1'b1;
                     end else if (!cont_nx && count == '0) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        run      <= 1'b0;
                        done_irq <= 1'b1;
                     end else begin
                        state    <= HIGH;
                        done_cnt <= ONE;
                     end
                  end else if (state == DONE) begin
                     state <= IDLE;
                  end
               end
               HIGH: begin
                  // phase counts 1..PERIOD across one pulse pitch.
                  phase <= phase + ONE;
                  if (phase == s_width) state <= LOW;
               end
               LOW: begin
                  if (phase == s_period) begin
                     if (s_cont || done_cnt < s_count) begin
                        state    <= HIGH;
                        phase    <= ONE;
                        done_cnt <= done_cnt + ONE;
                     end else begin
                        state    <= DONE;
                        done     <= 1'b1;
                        run      <= 1'b0;
                        done_irq <= 1'b1;
                     end
                  end else begin
                     phase <= phase + ONE;
                  end
               end
               default: state <= IDLE;
            endcase
         end else if (start_now) begin
            start_pend <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/ppt_pulse_gen_multi.sv
// Multi-channel pulse-train generator: register address decode, readback
// mux with registered read data, DONE_H coherency shadow, channel array.
//
// Register bus: reg_we and reg_re are single-cycle strobes with no
// back-pressure. A write takes effect at the sampling edge; read data is
// registered at the edge that samples reg_re and holds until the next read.
// A read and a write to the same address in one cycle return the old value.
module ppt_pulse_gen_multi
   import ppt_pkg::*;
#(
   parameter int N_CH  = 2,
   parameter int CNT_W = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ena,
   input  logic [7:0]      reg_addr,
   input  logic [7:0]      reg_wdata,
   input  logic            reg_we,
   input  logic            reg_re,
   output logic [7:0]      reg_rdata,
   output logic [N_CH-1:0] pulse_out,
   output logic [N_CH-1:0] done_irq
);

   logic [2:0]       chan;
   logic [3:0]       offset;
   logic [CNT_W-1:0] ch_period [N_CH];
   logic [CNT_W-1:0] ch_width [N_CH];
   logic [CNT_W-1:0] ch_count [N_CH];
   logic [CNT_W-1:0] ch_done_cnt [N_CH];
   logic             ch_run [N_CH];
   logic             ch_cont [N_CH];
   logic             ch_pol [N_CH];
   logic             ch_done [N_CH];
   logic             ch_err [N_CH];
   ppt_state_t       ch_state [N_CH];
   logic [7:0]       rd_val, done_h_live, done_h_shadow;
   logic             sel_valid;

   assign chan   = reg_addr[6:4];
   assign offset = reg_addr[3:0];

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      ppt_channel #(.CNT_W(CNT_W)) u_ch (
         .clk       (clk),
         .rst_n     (rst_n),
         .ena       (ena),
         .we        (reg_we && !reg_addr[7] && (chan == 3'(g))),
         .offset    (offset),
         .wdata     (reg_wdata),
         .period    (ch_period[g]),
         .width     (ch_width[g]),
         .count     (ch_count[g]),
         .done_cnt  (ch_done_cnt[g]),
         .run       (ch_run[g]),
         .cont      (ch_cont[g]),
         .pol       (ch_pol[g]),
         .done      (ch_done[g]),
         .err       (ch_err[g]),
         .pulse_out (pulse_out[g]),
         .done_irq  (done_irq[g]),
         .state     (ch_state[g])
      );
   end

   // Readback mux; unmapped offsets and absent channels read zero.
   always_comb begin
      rd_val      = '0;
      done_h_live = '0;
      sel_valid   = 1'b0;
      for (int c = 0; c < N_CH; c++) begin
         if (!reg_addr[7] && chan == 3'(c)) begin
            sel_valid   = 1'b1;
            done_h_live = get_byte(16'(ch_done_cnt[c]), 1'b1);
            case (offset)
               OFF_PERIOD_L, OFF_PERIOD_H: rd_val = get_byte(16'(ch_period[c]), offset[0]);
               OFF_WIDTH_L, OFF_WIDTH_H:   rd_val = get_byte(16'(ch_width[c]), offset[0]);
               OFF_COUNT_L, OFF_COUNT_H:   rd_val = get_byte(16'(ch_count[c]), offset[0]);
               OFF_CTRL: begin
                  rd_val[CTRL_RUN]  = ch_run[c];
                  rd_val[CTRL_CONT] = ch_cont[c];
                  rd_val[CTRL_POL]  = ch_pol[c];
               end
               OFF_DONE_L: rd_val = get_byte(16'(ch_done_cnt[c]), 1'b0);
               OFF_DONE_H: rd_val = done_h_shadow;
               OFF_STATUS: begin
                  rd_val[STAT_DONE] = ch_done[c];
                  rd_val[STAT_BUSY] = (ch_state[c] == HIGH) || (ch_state[c] == LOW);
                  rd_val[STAT_ERR]  = ch_err[c];
               end
               default: rd_val = '0;
            endcase
         end
      end
   end

   // Registered read data; DONE_L reads capture DONE_H so the pair is coherent.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg_rdata     <= '0;
         done_h_shadow <= '0;
      end else if (reg_re) begin
         reg_rdata <= rd_val;
         if (sel_valid && offset == OFF_DONE_L) done_h_shadow <= done_h_live;
      end
   end

endmodule

// File: tb/tb_ppt_pulse_gen_multi.sv
// Directed bench for ppt_pulse_gen_multi: a 2-channel 16-bit instance (a)
// and a 1-channel 8-bit instance (b) for the continuous-mode wrap case.
module tb_ppt_pulse_gen_multi;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [7:0] reg_addr, reg_wdata;
   logic       we_a, re_a, we_b, re_b;
   logic [7:0] rdata_a, rdata_b;
   logic [1:0] pulse_a, irq_a;
   logic [0:0] pulse_b, irq_b;

   int errors = 0;
   int checks = 0;

   ppt_pulse_gen_multi #(.N_CH(2), .CNT_W(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .ena(ena), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
      .reg_we(we_a), .reg_re(re_a), .reg_rdata(rdata_a), .pulse_out(pulse_a), .done_irq(irq_a));

   ppt_pulse_gen_multi #(.N_CH(1), .CNT_W(8)) dut_b (
      .clk(clk), .rst_n(rst_n), .ena(ena), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
      .reg_we(we_b), .reg_re(re_b), .reg_rdata(rdata_b), .pulse_out(pulse_b), .done_irq(irq_b));

   // clock
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int d, input logic [7:0] a, input logic [7:0] v);
      @(negedge clk);
      reg_addr  = a;
      reg_wdata = v;
      if (d == 0) we_a = 1'b1; else we_b = 1'b1;
      tick();
      we_a = 1'b0;
      we_b = 1'b0;
   endtask

   task automatic rd(input int d, input logic [7:0] a, output logic [7:0] v);
      @(negedge clk);
      reg_addr = a;
      if (d == 0) re_a = 1'b1; else re_b = 1'b1;
      tick();
      re_a = 1'b0;
      re_b = 1'b0;
      v = (d == 0) ? rdata_a : rdata_b;
   endtask

   task automatic cfg(input int d, input int ch, input int p, input int w, input int c);
      logic [7:0] base;
      base = 8'(ch << 4);
      wr(d, base | 8'h0, 8'(p));      wr(d, base | 8'h1, 8'(p >> 8));
      wr(d, base | 8'h2, 8'(w));      wr(d, base | 8'h3, 8'(w >> 8));
      wr(d, base | 8'h4, 8'(c));      wr(d, base | 8'h5, 8'(c >> 8));
   endtask

   initial begin
      logic [7:0] v, acc;
      logic       exp0, exp1;
      int         bad, irq_at, irq1_at, irq_n, hi_n, j;

      rst_n = 1'b0; ena = 1'b1; reg_addr = '0; reg_wdata = '0;
      we_a = 1'b0; re_a = 1'b0; we_b = 1'b0; re_b = 1'b0;
      #1;
      check("rst_pulse", pulse_a, 2'b00);
      check("rst_irq", irq_a, 2'b00);
      check("rst_rdata", rdata_a, 8'h00);
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      // 50 pulses, 4 high / 28 low, irq at cycle 1601
      cfg(0, 0, 32, 4, 50);
      wr(0, 8'h06, 8'h01);
      bad = 0; irq_at = 0; irq_n = 0;
      for (int i = 1; i <= 1601; i++) begin
         exp0 = (i <= 1600) && (((i - 1) % 32) < 4);
         if (pulse_a[0] !== exp0) bad++;
         if (irq_a[0] === 1'b1) begin irq_n++; if (irq_at == 0) irq_at = i; end
         if (i < 1601) tick();
      end
      check("t1_wave", bad, 0);
      check("t1_irq_cycle", irq_at, 1601);
      check("t1_irq_count", irq_n, 1);
      rd(0, 8'h08, v); check("t1_done_l", v, 8'h32);
      rd(0, 8'h09, v); check("t1_done_h", v, 8'h00);
      rd(0, 8'h0A, v); check("t1_status", v, 8'h01);
      rd(0, 8'h06, v); check("t1_ctrl_run_clr", v, 8'h00);

      // stop during pulse 20
      wr(0, 8'h06, 8'h01);
      repeat (609) tick();
      check("t2_pre_stop", pulse_a[0], 1'b1);
      wr(0, 8'h06, 8'h00);
      check("t2_stop_low", pulse_a[0], 1'b0);
      bad = 0;
      for (int i = 0; i < 700; i++) begin
         if (pulse_a[0] !== 1'b0 || irq_a[0] !== 1'b0) bad++;
         tick();
      end
      check("t2_quiet", bad, 0);
      rd(0, 8'h08, v); check("t2_done_l", v, 8'h14);
      rd(0, 8'h09, v); check("t2_done_h", v, 8'h00);
      rd(0, 8'h0A, v); check("t2_status", v, 8'h00);

      // PERIOD=0 error start
      wr(0, 8'h00, 8'h00);
      wr(0, 8'h06, 8'h01);
      hi_n = 0;
      for (int i = 0; i < 40; i++) begin
         if (pulse_a[0] !== 1'b0) hi_n++;
         tick();
      end
      check("t3_no_pulse", hi_n, 0);
      rd(0, 8'h0A, v); check("t3_status_err", v, 8'h05);

      // WIDTH >= PERIOD clamps to 31 high / 1 low
      wr(0, 8'h00, 8'd32);
      wr(0, 8'h02, 8'd40);
      wr(0, 8'h04, 8'd2);
      wr(0, 8'h06, 8'h01);
      bad = 0; irq_at = 0;
      for (int i = 1; i <= 65; i++) begin
         exp0 = (i <= 64) && (((i - 1) % 32) < 31);
         if (pulse_a[0] !== exp0) bad++;
         if (irq_a[0] === 1'b1 && irq_at == 0) irq_at = i;
         if (i < 65) tick();
      end
      check("t3_clamp_wave", bad, 0);
      check("t3_clamp_irq", irq_at, 65);
      rd(0, 8'h0A, v); check("t3_status_ok", v, 8'h01);

      // unmapped accesses and read-during-write
      rd(0, 8'h07, v); check("unmapped_off", v, 8'h00);
      wr(0, 8'h20, 8'h55);
      rd(0, 8'h20, v); check("absent_ch", v, 8'h00);
      rd(0, 8'h00, v); check("absent_no_alias", v, 8'd32);
      @(negedge clk);
      reg_addr = 8'h00; reg_wdata = 8'h11; we_a = 1'b1; re_a = 1'b1;
      tick();
      we_a = 1'b0; re_a = 1'b0;
      check("rw_same_old", rdata_a, 8'd32);
      rd(0, 8'h00, v); check("rw_same_new", v, 8'h11);

      // CONT mode on the 8-bit instance, 300 pulses, DONE_CNT wraps
      cfg(1, 0, 2, 1, 0);
      wr(1, 8'h06, 8'h03);
      bad = 0;
      for (int i = 1; i <= 600; i++) begin
         if (pulse_b[0] !== 1'((i % 2) == 1)) bad++;
         if (irq_b[0] !== 1'b0) bad++;
         if (i < 600) tick();
      end
      wr(1, 8'h06, 8'h00);
      check("t4_cont_wave", bad, 0);
      rd(1, 8'h08, v); check("t4_wrap_l", v, 8'd44);
      rd(1, 8'h09, v); check("t4_wrap_h", v, 8'h00);
      rd(1, 8'h0A, v); check("t4_status", v, 8'h00);
      wr(1, 8'h01, 8'hFF);
      rd(1, 8'h01, v); check("t4_hi_bits_zero", v, 8'h00);
      rd(1, 8'h00, v); check("t4_period_l", v, 8'd2);

      // two channels, ch1 inverted
      wr(0, 8'h16, 8'h04);
      check("t5_ch1_idle_high", pulse_a[1], 1'b1);
      cfg(0, 0, 10, 3, 3);
      cfg(0, 1, 6, 2, 4);
      wr(0, 8'h06, 8'h01);
      wr(0, 8'h16, 8'h05);
      bad = 0; irq_at = 0; irq1_at = 0;
      for (int i = 2; i <= 40; i++) begin
         j    = i - 1;
         exp0 = (i <= 30) && (((i - 1) % 10) < 3);
         exp1 = !((j <= 24) && (((j - 1) % 6) < 2));
         if (pulse_a[0] !== exp0) bad++;
         if (pulse_a[1] !== exp1) bad++;
         if (irq_a[0] === 1'b1 && irq_at == 0) irq_at = i;
         if (irq_a[1] === 1'b1 && irq1_at == 0) irq1_at = i;
         tick();
      end
      check("t5_wave", bad, 0);
      check("t5_irq0", irq_at, 31);
      check("t5_irq1", irq1_at, 26);

      // ena low for 10 cycles mid-pulse
      cfg(0, 0, 20, 8, 1);
      wr(0, 8'h06, 8'h01);
      hi_n = 0; irq_at = 0;
      for (int i = 1; i <= 40; i++) begin
         if (pulse_a[0] === 1'b1) hi_n++;
         if (irq_a[0] === 1'b1 && irq_at == 0) irq_at = i;
         @(negedge clk) ena = !(i >= 3 && i <= 12);
         tick();
      end
      ena = 1'b1;
      check("t6_stretch", hi_n, 18);
      check("t6_irq", irq_at, 31);

      // reset mid-run
      cfg(0, 0, 10, 5, 100);
      wr(0, 8'h06, 8'h01);
      wr(0, 8'h16, 8'h05);
      tick();
      rst_n = 1'b0;
      #1;
      check("t7_pulse_rst", pulse_a, 2'b00);
      check("t7_irq_rst", irq_a, 2'b00);
      @(negedge clk) rst_n = 1'b1;
      acc = '0;
      for (int ch = 0; ch < 2; ch++) begin
         for (int off = 0; off <= 10; off++) begin
            rd(0, 8'((ch << 4) | off), v);
            acc = acc | v;
         end
      end
      check("t7_regs_zero", acc, 8'h00);
      check("t7_pulse_after", pulse_a, 2'b00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
